// File: rtl/div32_seq_pkg.sv
// Shared ALU definitions for the sequential divider: default width, FSM
// encoding and the most-negative operand constant.
package div32_seq_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] MIN_INT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;
endpackage

// File: rtl/div32_seq_negate32.sv
// Two's-complement negator (invert plus increment), used for operand
// magnitudes and for result sign fix-up.
module negate32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = ~a_i + {{(WIDTH-1){1'b0}}, 1'b1};
endmodule

// File: rtl/div32_seq.sv
// Signed restoring divider, one quotient bit per clock, fixed 33-cycle
// latency from accept to done pulse; outputs held until the next op finishes.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q, r_q, d_q;
  logic             sign_q_q, sign_r_q, exc_q, zero_q;
  logic [WIDTH-1:0] result_q, rem_q;
  logic             exc_out_q, rdy_q, busy_q;

  logic [WIDTH-1:0] neg_a, neg_b, neg_q, neg_r;
  logic [WIDTH-1:0] abs_a, abs_b, shifted;
  logic [WIDTH:0]   trial;

  negate32 #(.WIDTH(WIDTH)) u_neg_a (.a_i(data_operandA), .y_o(neg_a));
  negate32 #(.WIDTH(WIDTH)) u_neg_b (.a_i(data_operandB), .y_o(neg_b));
  negate32 #(.WIDTH(WIDTH)) u_neg_q (.a_i(q_q),           .y_o(neg_q));
  negate32 #(.WIDTH(WIDTH)) u_neg_r (.a_i(r_q),           .y_o(neg_r));

  // Magnitudes are unsigned WIDTH-bit, so MIN_INT stays 0x80000000.
  assign abs_a   = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign abs_b   = data_operandB[WIDTH-1] ? neg_b : data_operandB;
  assign shifted = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {1'b0, d_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      exc_q     <= 1'b0;
      zero_q    <= 1'b0;
      result_q  <= '0;
      rem_q     <= '0;
      exc_out_q <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_div) begin
            sign_q_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r_q <= data_operandA[WIDTH-1];
            zero_q   <= (data_operandB == '0);
            exc_q    <= (data_operandB == '0) ||
                        ((data_operandA == MIN_INT) && (data_operandB == '1));
            q_q      <= abs_a;
            d_q      <= abs_b;
            r_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!trial[WIDTH]) begin
            r_q <= trial[WIDTH-1:0];
            q_q <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= shifted;
            q_q <= {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          // A zero divisor leaves all-ones garbage in Q; report clean zeros.
          if (zero_q) begin
            result_q <= '0;
            rem_q    <= '0;
          end else begin
            result_q <= sign_q_q ? neg_q : q_q;
            rem_q    <= sign_r_q ? neg_r : r_q;
          end
          exc_out_q <= exc_q;
          rdy_q     <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_out_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
endmodule
